// File: rtl/reset_sequencer.sv
//------------------------------------------------------------------------------
// reset_sequencer
//
// Staged reset controller for the switch datapath. A power-on/bench reset or a
// software request asserts every domain reset, holds them for HOLD_CYCLES, then
// releases domain 0, 1, ... NUM_STAGES-1 in order with STAGE_GAP cycles between
// consecutive releases.
//
// Ports:
//   clock         in   design clock, all logic on posedge
//   reset         in   synchronous active-low reset
//   sw_reset_req  in   software reset request (level or pulse)
//   stage_rst_n   out  [NUM_STAGES] active-low reset per domain, bit k = domain k
//   busy          out  high while any stage is held or the sequence is running
//   all_released  out  high in IDLE with every stage released
//   sw_reset_ack  out  one-cycle pulse when a software-initiated sequence ends
//------------------------------------------------------------------------------
module reset_sequencer #(
   parameter int NUM_STAGES  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4,
   parameter int CNT_W       = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  sw_reset_req,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  busy,
   output logic                  all_released,
   output logic                  sw_reset_ack
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   // Terminal counts pre-sized to the register widths they are compared with.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      RELEASE = 2'd1,
      IDLE    = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             req_seen;   // sequence was started or touched by software

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= ASSERT;
         cnt          <= '0;
         idx          <= '0;
         req_seen     <= 1'b0;
         stage_rst_n  <= '0;
         busy         <= 1'b1;
         all_released <= 1'b0;
         sw_reset_ack <= 1'b0;
      end else begin
         // Ack is a single-cycle pulse; only the completion edge raises it.
         sw_reset_ack <= 1'b0;

         case (state)
            ASSERT: begin
               // A request while holding only marks the sequence as software
               // owned; it never restarts the hold window.
               if (sw_reset_req) begin
                  req_seen <= 1'b1;
               end
               if (cnt == HOLD_LAST) begin
                  cnt            <= '0;
                  stage_rst_n[0] <= 1'b1;
                  if (NUM_STAGES == 1) begin
                     // Stage 0 is also the last stage: complete right here.
                     state        <= IDLE;
                     busy         <= 1'b0;
                     all_released <= 1'b1;
                     sw_reset_ack <= req_seen | sw_reset_req;
                     req_seen     <= 1'b0;
                  end else begin
                     state <= RELEASE;
                     idx   <= IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            RELEASE: begin
               if (sw_reset_req) begin
                  // Abort wins over everything, including a final release
                  // that would otherwise happen on this edge.
                  state       <= ASSERT;
                  stage_rst_n <= '0;
                  cnt         <= '0;
                  idx         <= '0;
                  req_seen    <= 1'b1;
               end else if (cnt == GAP_LAST) begin
                  stage_rst_n[idx] <= 1'b1;
                  cnt              <= '0;
                  if (idx == IDX_LAST) begin
                     state        <= IDLE;
                     busy         <= 1'b0;
                     all_released <= 1'b1;
                     sw_reset_ack <= req_seen;
                     req_seen     <= 1'b0;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            IDLE: begin
               if (sw_reset_req) begin
                  state        <= ASSERT;
                  stage_rst_n  <= '0;
                  busy         <= 1'b1;
                  all_released <= 1'b0;
                  cnt          <= '0;
                  idx          <= '0;
                  req_seen     <= 1'b1;
               end
            end

            default: begin
               state <= ASSERT;
            end
         endcase
      end
   end

endmodule
